capdriver_staged: RTL and testbench
===================================

CAPDRIVER_STAGED -- requirements
Module: capdriver_staged

Interface
REQ-001 Parameter WIDTH, default 16: capacitor drive bus width in bits.
REQ-002 Parameter GROUPS, default 4: number of update groups; WIDTH SHALL be an integer multiple of GROUPS; GW = WIDTH/GROUPS.
REQ-003 Parameter DLY_W, default 4: width of the inter-group delay field.
REQ-004 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 dac_state  input  WIDTH  new DAC state word.
REQ-007 dac_drive_invert  input  1  polarity control, active low: 1 = drive equals state, 0 = drive equals bitwise inverse of state.
REQ-008 stage_dly  input  DLY_W  number of idle cycles inserted between consecutive group updates.
REQ-009 load  input  1  request to apply a new state; accepted when load and ready are both high at a rising edge.
REQ-010 ready  output  1  high when idle and able to accept load.
REQ-011 busy  output  1  high while a staged update is in progress; always equals the inverse of ready.
REQ-012 done  output  1  single-cycle pulse marking completion of an update.
REQ-013 dac_drive  output  WIDTH  registered capacitor drive bus.

Function
REQ-014 Group k SHALL be defined as dac_drive bits [k*GW+GW-1 : k*GW]; group GROUPS-1 is the MSB group.
REQ-015 On acceptance (edge L), the block SHALL capture dac_state, dac_drive_invert and stage_dly into shadow registers; later input changes SHALL NOT affect the update in progress.
REQ-016 Target word SHALL be shadow_state XOR {WIDTH{~shadow_invert}}.
REQ-017 States SHALL be IDLE, UPDATE and WAIT; IDLE to UPDATE on acceptance; UPDATE writes one group; UPDATE to WAIT when the captured delay is nonzero and groups remain; WAIT to UPDATE after the captured delay count expires; UPDATE to IDLE after group 0 is written.
REQ-018 Groups SHALL be written MSB-first; group k SHALL be written at edge L+1+(GROUPS-1-k)*(D+1), where D is the captured stage_dly.
REQ-019 Groups not yet written SHALL hold their previous dac_drive value; bits SHALL never pass through any intermediate value.
REQ-020 At the edge that writes group 0, done SHALL go high for exactly one cycle, and ready SHALL go high.
REQ-021 With D=0, groups SHALL update on consecutive edges; total latency from acceptance to the final write SHALL be GROUPS + (GROUPS-1)*D cycles.
REQ-022 With GROUPS=1, the full word SHALL be written at edge L+1, and done SHALL assert at that edge.
REQ-023 load SHALL be ignored while ready is low; no queuing.
REQ-024 Back-to-back operation: a load held high SHALL be accepted at the first edge after done asserts, so ready is high for exactly one cycle between updates.
REQ-025 The delay counter SHALL be DLY_W bits wide and SHALL count D cycles exactly, including the maximum D of 2^DLY_W-1, with no wrap error.

Reset
REQ-026 Asserting rst SHALL immediately force: dac_drive = 0, state = IDLE, ready = 1, busy = 0, done = 0, shadow registers and counter = 0.
REQ-027 Reset asserted mid-update SHALL abort the update with no further group writes; after release, the block SHALL accept load on the first edge at which rst is low.

Verification (WIDTH=16, GROUPS=4, DLY_W=4)
REQ-028 Reset: assert rst → dac_drive=0x0000, ready=1, busy=0, done=0, with no clock edge required.
REQ-029 load with 0xA5C3, invert=1, dly=0 at edge L → dac_drive=0xA000 at L+1, 0xA500 at L+2, 0xA5C0 at L+3, 0xA5C3 at L+4; done=1 only in the cycle after L+4.
REQ-030 From 0xA5C3, load with 0x00FF, invert=0, dly=2 → target 0xFF00; dac_drive=0xF5C3 at L+1, 0xFFC3 at L+4, 0xFF03 at L+7, 0xFF00 at L+10; busy=1 throughout.
REQ-031 During the REQ-030 update, toggle load, dac_state, dac_drive_invert and stage_dly → no change to the sequence, and no second done pulse.
REQ-032 rst pulsed at L+2 of the REQ-029 sequence → dac_drive=0x0000 immediately, no further writes, ready=1; a load on the first edge after release is accepted.
REQ-033 load held high with dly=15 → group spacing is exactly 16 cycles; the second update is accepted at the first edge after done, with no lost or duplicated groups.

Source files
------------

// File: rtl/capdriver_staged.sv
// Staged capacitor-drive update: applies a new DAC word one group at a time, MSB group first.
// Latency GROUPS+(GROUPS-1)*D cycles from accept to final write; load accepted only while ready.
module capdriver_staged #(
  parameter int WIDTH  = 16,
  parameter int GROUPS = 4,
  parameter int DLY_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] dac_state,
  input  logic             dac_drive_invert,
  input  logic [DLY_W-1:0] stage_dly,
  input  logic             load,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dac_drive
);

  localparam int GW     = WIDTH / GROUPS;
  localparam int GIDX_W = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [GIDX_W-1:0] LAST_GRP = GIDX_W'(GROUPS - 1);

  typedef enum logic [1:0] {IDLE, UPDATE, WAIT} state_t;

  state_t             state_q, state_d;
  logic [GIDX_W-1:0]  grp_q, grp_d;
  logic [DLY_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   shadow_state_q, shadow_state_d;
  logic               shadow_inv_q, shadow_inv_d;
  logic [DLY_W-1:0]   shadow_dly_q, shadow_dly_d;
  logic [WIDTH-1:0]   drive_q, drive_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   target;

  // invert is active low: a cleared bit flips every drive line
  assign target = shadow_state_q ^ {WIDTH{~shadow_inv_q}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      grp_q          <= '0;
      cnt_q          <= '0;
      shadow_state_q <= '0;
      shadow_inv_q   <= 1'b0;
      shadow_dly_q   <= '0;
      drive_q        <= '0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      grp_q          <= grp_d;
      cnt_q          <= cnt_d;
      shadow_state_q <= shadow_state_d;
      shadow_inv_q   <= shadow_inv_d;
      shadow_dly_q   <= shadow_dly_d;
      drive_q        <= drive_d;
      done_q         <= done_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    grp_d          = grp_q;
    cnt_d          = cnt_q;
    shadow_state_d = shadow_state_q;
    shadow_inv_d   = shadow_inv_q;
    shadow_dly_d   = shadow_dly_q;
    drive_d        = drive_q;
    done_d         = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          shadow_state_d = dac_state;
          shadow_inv_d   = dac_drive_invert;
          shadow_dly_d   = stage_dly;
          grp_d          = LAST_GRP;
          cnt_d          = '0;
          state_d        = UPDATE;
        end
      end
      UPDATE: begin
        for (int g = 0; g < GROUPS; g++) begin
          if (GIDX_W'(g) == grp_q) drive_d[g*GW +: GW] = target[g*GW +: GW];
        end
        if (grp_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          grp_d = grp_q - GIDX_W'(1);
          if (shadow_dly_q != '0) begin
            state_d = WAIT;
            cnt_d   = shadow_dly_q;
          end
        end
      end
      WAIT: begin
        // leaving on the count of one gives exactly D idle cycles, even for D = max
        cnt_d = cnt_q - DLY_W'(1);
        if (cnt_q == DLY_W'(1)) state_d = UPDATE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready     = (state_q == IDLE);
  assign busy      = ~ready;
  assign done      = done_q;
  assign dac_drive = drive_q;

endmodule

// File: tb/tb_capdriver_staged.sv
// Directed and random stimulus for capdriver_staged, checked against a timing-formula model.
module tb_capdriver_staged;

  localparam int WIDTH  = 16;
  localparam int GROUPS = 4;
  localparam int DLY_W  = 4;
  localparam int GW     = WIDTH / GROUPS;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] dac_state;
  logic             dac_drive_invert;
  logic [DLY_W-1:0] stage_dly;
  logic             load;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dac_drive;

  int n_assert = 0;
  int n_fail   = 0;
  logic [WIDTH-1:0] model_drive;

  capdriver_staged #(.WIDTH(WIDTH), .GROUPS(GROUPS), .DLY_W(DLY_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .dac_state        (dac_state),
    .dac_drive_invert (dac_drive_invert),
    .stage_dly        (stage_dly),
    .load             (load),
    .ready            (ready),
    .busy             (busy),
    .done             (done),
    .dac_drive        (dac_drive)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: load dropped after accept; 1: inputs scrambled during update; 2: load held high
  task automatic drive_inputs(input int mode);
    if (mode == 1) begin
      load             = 1'($urandom_range(0, 1));
      dac_state        = WIDTH'($urandom);
      dac_drive_invert = 1'($urandom_range(0, 1));
      stage_dly        = DLY_W'($urandom);
    end else begin
      load = (mode == 2);
    end
  endtask

  // Group k is written t = 1+(GROUPS-1-k)*(D+1) cycles after the accept edge.
  task automatic do_update(input logic [WIDTH-1:0] st, input logic inv,
                           input logic [DLY_W-1:0] d, input int mode, input int stop_after);
    logic [WIDTH-1:0] tgt;
    logic [WIDTH-1:0] old;
    logic [WIDTH-1:0] exp;
    int total;
    int dd;
    dd    = int'(d);
    tgt   = inv ? st : ~st;
    old   = model_drive;
    total = GROUPS + (GROUPS - 1) * dd;
    chk("ready_before_load", 32'(ready), 32'(1));
    dac_state        = st;
    dac_drive_invert = inv;
    stage_dly        = d;
    load             = 1'b1;
    step();
    drive_inputs(mode);
    for (int t = 1; t <= total; t++) begin
      step();
      exp = old;
      for (int k = 0; k < GROUPS; k++) begin
        if (1 + (GROUPS - 1 - k) * (dd + 1) <= t) exp[k*GW +: GW] = tgt[k*GW +: GW];
      end
      chk("drive", 32'(dac_drive), 32'(exp));
      chk("busy",  32'(busy),  32'(t < total));
      chk("ready", 32'(ready), 32'(t == total));
      chk("done",  32'(done),  32'(t == total));
      model_drive = exp;
      if (t == stop_after) return;
      if (t < total) drive_inputs(mode);
    end
    if (mode != 2) load = 1'b0;
  endtask

  task automatic idle_check();
    step();
    chk("idle_done",  32'(done),      32'(0));
    chk("idle_ready", 32'(ready),     32'(1));
    chk("idle_drive", 32'(dac_drive), 32'(model_drive));
  endtask

  initial begin
    rst = 1'b0;
    load = 1'b0;
    dac_state = '0;
    dac_drive_invert = 1'b1;
    stage_dly = '0;
    model_drive = '0;
    #1 rst = 1'b1;
    #1;
    chk("rst_drive", 32'(dac_drive), 32'h0);
    chk("rst_ready", 32'(ready), 32'(1));
    chk("rst_busy",  32'(busy),  32'(0));
    chk("rst_done",  32'(done),  32'(0));
    step();
    step();
    rst = 1'b0;

    do_update(16'hA5C3, 1'b1, 4'd0, 0, 0);
    chk("a5c3_final", 32'(dac_drive), 32'h0000A5C3);
    idle_check();

    do_update(16'h00FF, 1'b0, 4'd2, 1, 0);
    chk("ff00_final", 32'(dac_drive), 32'h0000FF00);
    load = 1'b0;
    idle_check();
    idle_check();

    do_update(16'hA5C3, 1'b1, 4'd0, 0, 2);
    rst = 1'b1;
    #1;
    chk("abort_drive", 32'(dac_drive), 32'h0);
    chk("abort_ready", 32'(ready), 32'(1));
    chk("abort_busy",  32'(busy),  32'(0));
    chk("abort_done",  32'(done),  32'(0));
    model_drive = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_hold", 32'(dac_drive), 32'h0);
    end
    rst = 1'b0;
    do_update(16'h1234, 1'b1, 4'd1, 0, 0);
    idle_check();

    do_update(16'h5A5A, 1'b1, 4'd15, 2, 0);
    do_update(16'h5A5A, 1'b0, 4'd15, 2, 0);
    load = 1'b0;
    idle_check();

    for (int n = 0; n < 8; n++) begin
      do_update(WIDTH'($urandom), 1'($urandom_range(0, 1)),
                DLY_W'($urandom_range(0, 5)), int'($urandom_range(0, 1)), 0);
      load = 1'b0;
      idle_check();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
